// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a word-only data memory: sub-word RMW stores, lane-extracted loads.
// Build option: define MEM_ACCESS_PERF_EN to enable the saturating load/store response counters.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       load_count,
    output logic [15:0]       store_count
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_size;
    logic                r_signed;
    logic                r_write;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                w_req_err;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [DATA_W-1:0]   w_load_data;
    logic [DATA_W-1:0]   w_merge;

    assign w_req_err = (req_size == 2'b11) ||
                       (req_size == 2'b01 && req_addr[0]) ||
                       (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    assign req_ready  = (r_state == StIdle);
    assign mem_read   = (r_state == StRd);
    assign mem_write  = (r_state == StWr);
    assign resp_valid = (r_state == StResp);
    assign resp_err   = (r_state == StResp) && r_err;
    assign resp_rdata = r_rdata;
    assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = r_mem_wdata;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (req_valid) begin
                    if (w_req_err) begin
                        w_state_d = StResp;
                    end else if (req_write && req_size == 2'b10) begin
                        w_state_d = StWr;
                    end else begin
                        w_state_d = StRd;
                    end
                end
            end
            StRd:    w_state_d = r_write ? StWr : StResp;
            StWr:    w_state_d = StResp;
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Lane extraction and extension from the live read data, captured on the edge leaving RD.
    always_comb begin
        w_byte      = 8'(mem_rdata >> {r_addr[1:0], 3'b000});
        w_half      = 16'(mem_rdata >> {r_addr[1], 4'b0000});
        w_load_data = mem_rdata;
        if (r_size == 2'b00) begin
            w_load_data = {{(DATA_W-8){r_signed & w_byte[7]}}, w_byte};
        end else if (r_size == 2'b01) begin
            w_load_data = {{(DATA_W-16){r_signed & w_half[15]}}, w_half};
        end
    end

    // Store data is still right-justified in r_mem_wdata while in RD.
    always_comb begin
        w_merge = mem_rdata;
        if (r_size == 2'b00) begin
            w_merge[{r_addr[1:0], 3'b000} +: 8] = r_mem_wdata[7:0];
        end else begin
            w_merge[{r_addr[1], 4'b0000} +: 16] = r_mem_wdata[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_write     <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_state_d;
            unique case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_addr   <= req_addr;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_write  <= req_write;
                        r_err    <= w_req_err;
                        if (w_req_err) begin
                            r_rdata <= '0;
                        end else if (req_write) begin
                            r_mem_wdata <= req_wdata;
                        end
                    end
                end
                StRd: begin
                    if (r_write) begin
                        r_mem_wdata <= w_merge;
                    end else begin
                        r_rdata <= w_load_data;
                    end
                end
                StWr:    r_rdata <= '0;
                default: ;
            endcase
        end
    end

`ifdef MEM_ACCESS_PERF_EN
    logic [15:0] r_load_cnt;
    logic [15:0] r_store_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_load_cnt  <= '0;
            r_store_cnt <= '0;
        end else if (r_state == StResp && !r_err) begin
            if (r_write) begin
                if (r_store_cnt != 16'hFFFF) r_store_cnt <= r_store_cnt + 16'd1;
            end else begin
                if (r_load_cnt != 16'hFFFF) r_load_cnt <= r_load_cnt + 16'd1;
            end
        end
    end

    assign load_count  = r_load_cnt;
    assign store_count = r_store_cnt;
`else
    assign load_count  = 16'd0;
    assign store_count = 16'd0;
`endif

endmodule
